// File: rtl/counter_pkg.sv
// counter_pkg
// Shared types and defaults for the counter control slice.
//   op_e          : command opcodes carried on cmd_op_i
//   state_e       : controller states
//   COUNTER_WIDTH : default counter width
package counter_pkg;

    localparam int COUNTER_WIDTH = 4;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'd0,
        OP_CLEAR  = 2'd1,
        OP_RUN_N  = 2'd2,
        OP_RUN_TO = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CALC  = 3'd2,
        ST_RUN   = 3'd3,
        ST_CHECK = 3'd4
    } state_e;

endpackage

// File: rtl/counter_ctrl.sv
// counter_ctrl
// Command-driven initiator for a loadable up-counter. Accepts LOAD, CLEAR,
// RUN_N and RUN_TO commands over valid/ready, drives the counter's
// enable/load/data pins, then reads the count back and reports completion
// with a mismatch flag.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset (shared with the counter)
//   cmd_valid_i  command present
//   cmd_ready_o  controller idle and out of reset
//   cmd_op_i     opcode (op_e)
//   cmd_data_i   load value / cycle count / target, by opcode
//   count_i      counter output
//   enable_o     counter increment request
//   load_o       counter load request
//   data_o       counter load value (zero outside LOAD)
//   done_o       one-cycle completion pulse
//   err_o        final count differed from expected (only with done_o)
//   busy_o       command in progress
module counter_ctrl
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_op_i,
    input  logic [WIDTH-1:0] cmd_data_i,
    input  logic [WIDTH-1:0] count_i,
    output logic             enable_o,
    output logic             load_o,
    output logic [WIDTH-1:0] data_o,
    output logic             done_o,
    output logic             err_o,
    output logic             busy_o
);

    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_r;
    state_e           state_next_s;
    op_e              op_r;
    op_e              cmd_op_s;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] remaining_r;
    logic [WIDTH-1:0] expected_r;
    logic             accept_s;
    logic [WIDTH-1:0] load_value_s;
    logic [WIDTH-1:0] calc_remaining_s;
    logic [WIDTH-1:0] calc_expected_s;

    // Handshake: ready only when idle and reset is not asserted this cycle.
    always_comb begin
        cmd_op_s    = op_e'(cmd_op_i);
        cmd_ready_o = (state_r == ST_IDLE) && !rst_i;
        accept_s    = cmd_valid_i && cmd_ready_o;
    end

    // Load value and run arithmetic derived from the latched command.
    // RUN_TO distance wraps modulo 2^WIDTH so a target below the current
    // count runs through the top value and back to zero.
    always_comb begin
        if (op_r == OP_LOAD) begin
            load_value_s = data_r;
        end else begin
            load_value_s = ZERO_C;
        end
        case (op_r)
            OP_RUN_TO: begin
                calc_remaining_s = data_r - count_i;
                calc_expected_s  = data_r;
            end
            OP_RUN_N: begin
                calc_remaining_s = data_r;
                calc_expected_s  = count_i + data_r;
            end
            default: begin
                calc_remaining_s = ZERO_C;
                calc_expected_s  = count_i;
            end
        endcase
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if ((cmd_op_s == OP_LOAD) || (cmd_op_s == OP_CLEAR)) begin
                        state_next_s = ST_LOAD;
                    end else begin
                        state_next_s = ST_CALC;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: state_next_s = ST_CHECK;
            ST_CALC: begin
                if (calc_remaining_s != ZERO_C) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_CHECK;
                end
            end
            // Leave RUN on the cycle carrying the last enable.
            ST_RUN: begin
                if (remaining_r == ONE_C) begin
                    state_next_s = ST_CHECK;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_CHECK: state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Moore output decode from the state register.
    always_comb begin
        enable_o = 1'b0;
        load_o   = 1'b0;
        data_o   = ZERO_C;
        done_o   = 1'b0;
        err_o    = 1'b0;
        busy_o   = (state_r != ST_IDLE);
        case (state_r)
            ST_LOAD: begin
                load_o = 1'b1;
                data_o = load_value_s;
            end
            ST_RUN: enable_o = 1'b1;
            ST_CHECK: begin
                done_o = 1'b1;
                err_o  = (count_i != expected_r);
            end
            default: begin
                enable_o = 1'b0;
                load_o   = 1'b0;
            end
        endcase
    end

    // State, command latch, remaining-cycle down-counter and expected value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            op_r        <= OP_LOAD;
            data_r      <= ZERO_C;
            remaining_r <= ZERO_C;
            expected_r  <= ZERO_C;
        end else begin
            state_r <= state_next_s;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r   <= cmd_op_s;
                        data_r <= cmd_data_i;
                    end
                end
                ST_LOAD: expected_r <= load_value_s;
                ST_CALC: begin
                    remaining_r <= calc_remaining_s;
                    expected_r  <= calc_expected_s;
                end
                ST_RUN: remaining_r <= remaining_r - ONE_C;
                default: begin
                    remaining_r <= remaining_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl
// Directed bench for counter_ctrl with a behavioural counter beside it
// (switchable to a stub holding 4). A cycle-timeline model of the
// controller is compared against the DUT on every cycle; each command also
// carries hand-computed latency / final-count / error expectations.
module tb_counter_ctrl;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [3:0] count_feed;
    logic       enable;
    logic       load;
    logic [3:0] data;
    logic       done;
    logic       err;
    logic       busy;

    logic [3:0] cnt;
    bit         use_stub;

    int n_cmp;
    int n_bad;

    counter_ctrl #(.WIDTH(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_op_i   (cmd_op),
        .cmd_data_i (cmd_data),
        .count_i    (count_feed),
        .enable_o   (enable),
        .load_o     (load),
        .data_o     (data),
        .done_o     (done),
        .err_o      (err),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Real counter: load has priority over enable, wraps modulo 16.
    always @(posedge clk) begin
        if (rst)         cnt <= 4'd0;
        else if (load)   cnt <= data;
        else if (enable) cnt <= cnt + 4'd1;
    end

    assign count_feed = use_stub ? 4'd4 : cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: for an accepted command, position k (cycles since the
    // accept edge) alone determines every output.
    int         m_cyc;
    int         m_acc;
    int         m_k;
    int         m_dk;
    int         m_r;
    bit         m_active;
    bit         m_valid;
    logic [1:0] m_op;
    logic [3:0] m_data;
    logic [3:0] m_exp;
    logic [3:0] m_val;
    logic       e_en, e_ld, e_done, e_err, e_busy, e_ready;
    logic [3:0] e_dat;

    initial begin
        m_cyc = 0; m_acc = 0; m_active = 1'b0; m_valid = 1'b0;
        m_r = 0; m_dk = 0; m_op = 2'd0; m_data = 4'd0; m_exp = 4'd0;
        forever begin
            @(negedge clk);
            m_cyc++;
            m_k     = m_cyc - m_acc;
            e_en    = 1'b0; e_ld = 1'b0; e_dat = 4'd0; e_done = 1'b0; e_err = 1'b0;
            e_busy  = m_active;
            e_ready = !m_active && !rst;
            if (m_active) begin
                if (m_op == 2'd0 || m_op == 2'd1) begin
                    m_val = (m_op == 2'd0) ? m_data : 4'd0;
                    m_dk  = 2;
                    if (m_k == 1) begin e_ld = 1'b1; e_dat = m_val; end
                    if (m_k == 2) begin e_done = 1'b1; e_err = (count_feed != m_val); end
                end else begin
                    if (m_k == 1) begin
                        if (m_op == 2'd2) begin
                            m_r   = int'(m_data);
                            m_exp = 4'((int'(count_feed) + int'(m_data)) % 16);
                        end else begin
                            m_r   = ((int'(m_data) - int'(count_feed)) % 16 + 16) % 16;
                            m_exp = m_data;
                        end
                    end
                    m_dk = m_r + 2;
                    if (m_k >= 2 && m_k <= m_r + 1) e_en = 1'b1;
                    if (m_k == m_dk) begin e_done = 1'b1; e_err = (count_feed != m_exp); end
                end
            end
            if (m_valid) begin
                check("enable_o", enable, e_en);
                check("load_o", load, e_ld);
                check("data_o", data, e_dat);
                check("done_o", done, e_done);
                check("busy_o", busy, e_busy);
                check("cmd_ready_o", cmd_ready, e_ready);
                if (e_done) check("err_o", err, e_err);
            end
            if (rst) begin
                m_active = 1'b0;
                m_valid  = 1'b1;
            end else if (m_active && m_k == m_dk) begin
                m_active = 1'b0;
            end else if (!m_active && cmd_valid) begin
                m_active = 1'b1;
                m_acc    = m_cyc;
                m_op     = cmd_op;
                m_data   = cmd_data;
            end
        end
    end

    // Issue one command and check hand-computed results.
    task automatic do_cmd(input logic [1:0] op, input logic [3:0] d, input bit hold,
                          input int exp_k, input int exp_cnt, input int exp_err,
                          input int exp_en, input int exp_ld, input int exp_ld_data);
        int k, n_en, n_ld, ld_data, waitc;
        bit got;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        got = 1'b0; waitc = 0;
        while (!got && waitc < 20) begin
            @(negedge clk);
            if (cmd_ready) got = 1'b1;
            waitc++;
        end
        check("accept", got, 1);
        if (!got) begin
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (hold) begin
            cmd_op = 2'd0; cmd_data = 4'hF;
        end else begin
            cmd_valid = 1'b0;
        end
        k = 0; n_en = 0; n_ld = 0; ld_data = -1; got = 1'b0;
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            if (enable) n_en++;
            if (load) begin n_ld++; ld_data = int'(data); end
            if (done) got = 1'b1;
        end
        check("done_seen", got, 1);
        check("done_cycle", k, exp_k);
        check("enable_cycles", n_en, exp_en);
        check("load_cycles", n_ld, exp_ld);
        if (n_ld > 0) check("load_data", ld_data, exp_ld_data);
        if (got) begin
            check("final_count", count_feed, exp_cnt);
            check("final_err", err, exp_err);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    initial begin
        int n_done;
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 4'd0; use_stub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ready", cmd_ready, 0);
        check("rst_enable", enable, 0);
        check("rst_load", load, 0);
        check("rst_data", data, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", cmd_ready, 1);

        do_cmd(2'd0, 4'd9, 1'b0, 2, 9, 0, 0, 1, 9);    // LOAD 9
        do_cmd(2'd2, 4'd5, 1'b0, 7, 14, 0, 5, 0, 0);   // RUN_N 5 from 9
        do_cmd(2'd3, 4'd3, 1'b0, 7, 3, 0, 5, 0, 0);    // RUN_TO 3 from 14, wraps
        do_cmd(2'd2, 4'd0, 1'b1, 2, 3, 0, 0, 0, 0);    // RUN_N 0, valid held
        do_cmd(2'd3, 4'd3, 1'b1, 2, 3, 0, 0, 0, 0);    // RUN_TO current, valid held

        use_stub = 1'b1;
        do_cmd(2'd2, 4'd2, 1'b0, 4, 4, 1, 2, 0, 0);    // stub: expected 6, sees 4
        do_cmd(2'd1, 4'd7, 1'b0, 2, 4, 1, 0, 1, 0);    // stub: CLEAR, sees 4
        use_stub = 1'b0;

        // RUN_N 10 aborted by reset in the third enable cycle.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_data = 4'd10;
        @(negedge clk);
        check("abort_ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("abort_third_enable", enable, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_enable_drop", enable, 0);
        check("abort_no_done", done, 0);
        check("abort_busy", busy, 0);
        check("abort_ready_back", cmd_ready, 1);
        check("abort_count", count_feed, 0);
        n_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_late_done", n_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
